// File: rtl/mux_2x1_arbiter.sv
// Two-port round-robin arbiter driving a shared 2:1 mux onto a valid/ready channel.
// Grants are burst-limited so a busy port cannot starve the other.
module mux_2x1_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] outp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic own_req;
    logic oth_req;
    logic oth_port;
    logic xfer;

    assign gnt0      = (state_q == OWN0);
    assign gnt1      = (state_q == OWN1);
    assign sel       = sel_q;
    assign busy      = gnt0 | gnt1;
    assign outp      = sel_q ? d1 : d0;
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign xfer      = out_valid & out_ready;

    assign own_req  = gnt1 ? req1 : req0;
    assign oth_req  = gnt1 ? req0 : req1;
    assign oth_port = gnt0;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 & req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                    sel_d   = ~last_q;
                    last_d  = ~last_q;
                    cnt_d   = '0;
                end else if (req0) begin
                    state_d = OWN0;
                    sel_d   = 1'b0;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end else if (req1) begin
                    state_d = OWN1;
                    sel_d   = 1'b1;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    cnt_d = '0;
                    if (oth_req) begin
                        state_d = oth_port ? OWN1 : OWN0;
                        sel_d   = oth_port;
                        last_d  = oth_port;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (xfer) begin
                    if (cnt_q == CNT_LAST) begin
                        // burst exhausted: hand over only if the other side waits
                        cnt_d = '0;
                        if (oth_req) begin
                            state_d = oth_port ? OWN1 : OWN0;
                            sel_d   = oth_port;
                            last_d  = oth_port;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Bench for mux_2x1_arbiter: directed scenarios plus random traffic
// against an integer-level ownership model.
module tb_mux_2x1_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, out_ready;
    logic [WIDTH-1:0] d0, d1;
    logic             gnt0, gnt1, sel, out_valid, busy;
    logic [WIDTH-1:0] outp;

    int checks = 0;
    int errors = 0;

    // model: owner 0/1, 2 = nobody
    int m_owner, m_cnt, m_last, m_sel;

    mux_2x1_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .d0(d0), .req1(req1), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .outp(outp),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [WIDTH+4:0] obs = {gnt0, gnt1, sel, busy, out_valid, outp};

    function automatic logic [WIDTH+4:0] exp_vec();
        logic v;
        v = (m_owner == 0 && req0) || (m_owner == 1 && req1);
        return {m_owner == 0, m_owner == 1, m_sel[0], m_owner != 2, v,
                (m_sel != 0) ? d1 : d0};
    endfunction

    function automatic void model_reset();
        m_owner = 2; m_cnt = 0; m_last = 1; m_sel = 0;
    endfunction

    function automatic void model_give(input int p);
        m_owner = p; m_sel = p; m_last = p; m_cnt = 0;
    endfunction

    function automatic void model_edge(input bit r0, input bit r1, input bit rdy);
        bit mine, other;
        if (m_owner == 2) begin
            if (r0 && r1) model_give(m_last == 1 ? 0 : 1);
            else if (r0) model_give(0);
            else if (r1) model_give(1);
        end else begin
            mine  = (m_owner == 0) ? r0 : r1;
            other = (m_owner == 0) ? r1 : r0;
            if (!mine) begin
                if (other) model_give(1 - m_owner);
                else begin m_owner = 2; m_cnt = 0; end
            end else if (rdy) begin
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_cnt = 0;
                    if (other) model_give(1 - m_owner);
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(req0, req1, out_ready);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0; out_ready = 0;
        d0 = 8'hA5; d1 = 8'h5A;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs !== {5'b00000, 8'hA5}) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, {5'b00000, 8'hA5});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (obs !== exp_vec() || outp !== 8'hA5) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        req1 = 1; d1 = 8'h3C; out_ready = 1;
        step();
        checks++;
        if (gnt1 !== 1'b1 || sel !== 1'b1 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: gnt1=%b sel=%b gnt0=%b want 1 1 0",
                     gnt1, sel, gnt0);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (obs !== exp_vec() || outp !== 8'h3C || !out_valid) begin
                errors++;
                $display("FAIL single_hold[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        req1 = 0;
        step();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL single_release: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_tie_burst();
        bit want0;
        do_reset();
        req0 = 1; req1 = 1; out_ready = 1;
        for (int i = 0; i < 14; i++) begin
            step();
            want0 = ((i / MAX_BURST) % 2) == 0;
            checks++;
            if (gnt0 !== want0 || gnt1 !== !want0 || sel !== !want0
                || obs !== exp_vec()) begin
                errors++;
                $display("FAIL tie_burst[%0d]: gnt0=%b gnt1=%b sel=%b want %b %b %b",
                         i, gnt0, gnt1, sel, want0, !want0, !want0);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        req0 = 1; req1 = 1; out_ready = 0;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (gnt0 !== 1'b1 || obs !== exp_vec()) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (gnt0 !== (i < MAX_BURST - 1) || obs !== exp_vec()) begin
                errors++;
                $display("FAIL bp_drain[%0d]: gnt0=%b want %b", i, gnt0,
                         i < MAX_BURST - 1);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        req0 = 1; req1 = 0; out_ready = 1;
        step();
        step();
        req0 = 0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL abort_valid: out_valid=%b gnt0=%b want 0 1", out_valid, gnt0);
        end
        step();
        checks++;
        if (busy !== 1'b0 || obs !== exp_vec()) begin
            errors++;
            $display("FAIL abort_idle: got %h want %h", obs, exp_vec());
        end
        req0 = 1; req1 = 1;
        step();
        checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || sel !== 1'b1) begin
            errors++;
            $display("FAIL abort_tie: gnt0=%b gnt1=%b sel=%b want 0 1 1", gnt0, gnt1, sel);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req0 = 0; req1 = 1; out_ready = 1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (gnt1 !== 1'b0 || sel !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt1=%b sel=%b busy=%b valid=%b want 0 0 0 0",
                     gnt1, sel, busy, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1; req1 = 1;
        step();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || sel !== 1'b0) begin
            errors++;
            $display("FAIL async_tie: gnt0=%b gnt1=%b sel=%b want 1 0 0", gnt0, gnt1, sel);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req0      = ($urandom_range(0, 9) < 7);
            req1      = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 3) != 0);
            d0        = WIDTH'($urandom);
            d1        = WIDTH'($urandom);
            #1;
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_pre[%0d]: got %h want %h", i, obs, exp_vec());
            end
            step();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_post[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 0; req1 = 0; out_ready = 0; d0 = '0; d1 = '0;
        model_reset();
        test_reset();
        test_single();
        test_tie_burst();
        test_back_pressure();
        test_abort();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
